// File: rtl/seq_pkg.sv
// Shared types for the sequence-detection path: serializer FSM states,
// detector states and the default word width.
package seq_pkg;

    // Serializer control: either nothing is on the line, or a word is
    // being shifted out one bit per clock.
    typedef enum logic {
        SER_IDLE  = 1'b0,
        SER_SHIFT = 1'b1
    } ser_state_t;

    // States of the downstream 110 Mealy detector fed by the serializer.
    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2
    } det_state_t;

    localparam int DEFAULT_DATA_W = 8;

endpackage

// File: rtl/seq_hold_buf.sv
// Single-entry holding register with a full flag. It captures a word that
// arrives while the shifter is busy, and hands it over (pop) on the edge
// that retires the shifter's last bit.
module seq_hold_buf
    import seq_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              full
);

    logic [DATA_W-1:0] data_reg;
    logic              full_reg;

    // Clear beats write beats pop; write and pop are never requested together
    // because a word arriving on the reload edge bypasses the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg <= '0;
            full_reg <= 1'b0;
        end else if (clr) begin
            data_reg <= '0;
            full_reg <= 1'b0;
        end else if (wr) begin
            data_reg <= wdata;
            full_reg <= 1'b1;
        end else if (pop) begin
            full_reg <= 1'b0;
        end
    end

    assign rdata = data_reg;
    assign full  = full_reg;

endmodule

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder for the 110 sequence detector. Words arrive over
// a valid/ready handshake and leave one bit per clock with valid/last
// qualifiers. A one-word hold buffer lets consecutive words stream without
// an idle cycle between them.
module seq_bit_serializer
    import seq_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              flush,
    output logic              ser_bit,
    output logic              ser_valid,
    output logic              ser_last,
    output logic              busy
);

    localparam int              CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(DATA_W - 2);

    ser_state_t        state_reg;
    logic [DATA_W-1:0] shift_reg;     // bits still to send, next one at the MSB
    logic [CNT_W-1:0]  cnt_reg;       // index of the bit currently on ser_bit
    logic              ready_en_reg;  // holds s_ready low until the first edge out of reset
    logic              bit_reg;
    logic              valid_reg;
    logic              last_reg;

    logic              hold_full;
    logic [DATA_W-1:0] hold_data;

    logic              xfer;
    logic              last_edge;
    logic              hold_wr;
    logic              hold_pop;
    logic              load;
    logic [DATA_W-1:0] load_word;
    logic [DATA_W-1:0] ordered_word;  // load_word rearranged into send order, first bit at MSB

    // Handshake: a slot exists whenever the hold buffer is empty; flush
    // forces ready low so no word can be accepted and then dropped.
    assign s_ready = ready_en_reg && !hold_full && !flush;
    assign xfer    = s_valid && s_ready;

    // The edge that retires the final bit of the word on the line.
    assign last_edge = (state_reg == SER_SHIFT) && (cnt_reg == LAST_IDX);

    // A mid-word arrival parks in the hold buffer; on the retiring edge a
    // held word takes priority, otherwise a fresh arrival goes straight in.
    assign hold_wr  = xfer && (state_reg == SER_SHIFT) && !last_edge;
    assign hold_pop = last_edge && hold_full;
    assign load     = ((state_reg == SER_IDLE) && xfer) ||
                      (last_edge && (hold_full || xfer));
    assign load_word = hold_pop ? hold_data : s_data;

    // Reorder the word once at load so the shifter always moves MSB-first.
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_order
        if (MSB_FIRST) begin : g_msb
            assign ordered_word[gi] = load_word[gi];
        end else begin : g_lsb
            assign ordered_word[DATA_W-1-gi] = load_word[gi];
        end
    end

    seq_hold_buf #(
        .DATA_W (DATA_W)
    ) u_hold (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .wr    (hold_wr),
        .wdata (s_data),
        .pop   (hold_pop),
        .rdata (hold_data),
        .full  (hold_full)
    );

    // Serializer FSM with registered bit/valid/last outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= SER_IDLE;
            shift_reg    <= '0;
            cnt_reg      <= '0;
            ready_en_reg <= 1'b0;
            bit_reg      <= IDLE_BIT;
            valid_reg    <= 1'b0;
            last_reg     <= 1'b0;
        end else begin
            ready_en_reg <= 1'b1;
            if (flush) begin
                // Abort: drop the in-flight word (hold buffer clears itself).
                state_reg <= SER_IDLE;
                shift_reg <= '0;
                cnt_reg   <= '0;
                bit_reg   <= IDLE_BIT;
                valid_reg <= 1'b0;
                last_reg  <= 1'b0;
            end else if (load) begin
                // First bit goes out now; the rest wait in the shifter.
                state_reg <= SER_SHIFT;
                shift_reg <= {ordered_word[DATA_W-2:0], 1'b0};
                cnt_reg   <= '0;
                bit_reg   <= ordered_word[DATA_W-1];
                valid_reg <= 1'b1;
                last_reg  <= 1'b0;
            end else if (last_edge) begin
                // Word finished with nothing queued behind it.
                state_reg <= SER_IDLE;
                shift_reg <= '0;
                cnt_reg   <= '0;
                bit_reg   <= IDLE_BIT;
                valid_reg <= 1'b0;
                last_reg  <= 1'b0;
            end else if (state_reg == SER_SHIFT) begin
                shift_reg <= shift_reg << 1;
                cnt_reg   <= cnt_reg + CNT_W'(1);
                bit_reg   <= shift_reg[DATA_W-1];
                valid_reg <= 1'b1;
                last_reg  <= (cnt_reg == PRE_LAST);
            end
        end
    end

    assign ser_bit   = bit_reg;
    assign ser_valid = valid_reg;
    assign ser_last  = last_reg;
    assign busy      = (state_reg == SER_SHIFT) || hold_full;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Directed bench for seq_bit_serializer: one MSB-first and one LSB-first
// instance share clock and reset. Inputs change and outputs are checked on
// the falling edge, half a cycle away from the active edge.
module tb_seq_bit_serializer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic [7:0] s_data_m = '0;
    logic       s_valid_m = 1'b0;
    logic       flush_m = 1'b0;
    logic       s_ready_m, ser_bit_m, ser_valid_m, ser_last_m, busy_m;

    logic [7:0] s_data_l = '0;
    logic       s_valid_l = 1'b0;
    logic       flush_l = 1'b0;
    logic       s_ready_l, ser_bit_l, ser_valid_l, ser_last_l, busy_l;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_bit_serializer #(.DATA_W(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_data    (s_data_m),
        .s_valid   (s_valid_m),
        .s_ready   (s_ready_m),
        .flush     (flush_m),
        .ser_bit   (ser_bit_m),
        .ser_valid (ser_valid_m),
        .ser_last  (ser_last_m),
        .busy      (busy_m)
    );

    seq_bit_serializer #(.DATA_W(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_data    (s_data_l),
        .s_valid   (s_valid_l),
        .s_ready   (s_ready_l),
        .flush     (flush_l),
        .ser_bit   (ser_bit_l),
        .ser_valid (ser_valid_l),
        .ser_last  (ser_last_l),
        .busy      (busy_l)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] pat;

        // 1. reset / idle
        repeat (3) @(negedge clk);
        chk("rst s_ready_m", 8'(s_ready_m), 8'd0);
        chk("rst ser_valid_m", 8'(ser_valid_m), 8'd0);
        chk("rst ser_bit_m", 8'(ser_bit_m), 8'd0);
        chk("rst busy_m", 8'(busy_m), 8'd0);
        chk("rst ser_valid_l", 8'(ser_valid_l), 8'd0);
        rst_n = 1'b1;
        #1;
        chk("rel s_ready before edge", 8'(s_ready_m), 8'd0);
        step();
        chk("rel s_ready after edge", 8'(s_ready_m), 8'd1);
        chk("rel s_ready_l", 8'(s_ready_l), 8'd1);
        chk("rel ser_valid", 8'(ser_valid_m), 8'd0);
        chk("rel busy", 8'(busy_m), 8'd0);
        $display("txn reset: done");

        // 2. single word, MSB first: 0110_1100 -> 0,1,1,0,1,1,0,0
        s_data_m = 8'b0110_1100; s_valid_m = 1'b1;
        step();
        s_valid_m = 1'b0;
        pat = 8'b0110_1100;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t2 valid%0d", i), 8'(ser_valid_m), 8'd1);
            chk($sformatf("t2 bit%0d", i), 8'(ser_bit_m), 8'(pat[7-i]));
            chk($sformatf("t2 last%0d", i), 8'(ser_last_m), 8'(i == 7));
            step();
        end
        chk("t2 valid after", 8'(ser_valid_m), 8'd0);
        chk("t2 bit after", 8'(ser_bit_m), 8'd0);
        chk("t2 busy after", 8'(busy_m), 8'd0);
        $display("txn single 6c: done");

        // 3. back-to-back FF then 00, zero gap
        s_data_m = 8'hFF; s_valid_m = 1'b1;
        step();
        for (int i = 0; i < 16; i++) begin
            if (i == 0) s_data_m = 8'h00;
            if (i == 1) s_valid_m = 1'b0;
            chk($sformatf("t3 valid%0d", i), 8'(ser_valid_m), 8'd1);
            chk($sformatf("t3 bit%0d", i), 8'(ser_bit_m), 8'(i < 8));
            chk($sformatf("t3 last%0d", i), 8'(ser_last_m), 8'((i == 7) || (i == 15)));
            chk($sformatf("t3 ready%0d", i), 8'(s_ready_m), 8'((i == 0) || (i >= 8)));
            step();
        end
        chk("t3 valid after", 8'(ser_valid_m), 8'd0);
        chk("t3 busy after", 8'(busy_m), 8'd0);
        $display("txn back-to-back ff/00: done");

        // 4. LSB first: 0000_0011 -> 1,1,0,0,0,0,0,0
        s_data_l = 8'b0000_0011; s_valid_l = 1'b1;
        step();
        s_valid_l = 1'b0;
        pat = 8'b0000_0011;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t4 valid%0d", i), 8'(ser_valid_l), 8'd1);
            chk($sformatf("t4 bit%0d", i), 8'(ser_bit_l), 8'(pat[i]));
            chk($sformatf("t4 last%0d", i), 8'(ser_last_l), 8'(i == 7));
            step();
        end
        chk("t4 valid after", 8'(ser_valid_l), 8'd0);
        $display("txn lsb-first 03: done");

        // 5. flush on the edge retiring bit 3 of A5, with 3C held
        s_data_m = 8'hA5; s_valid_m = 1'b1;
        step();
        chk("t5 bit0", 8'(ser_bit_m), 8'd1);
        s_data_m = 8'h3C;
        step();
        s_valid_m = 1'b0;
        chk("t5 bit1", 8'(ser_bit_m), 8'd0);
        chk("t5 hold busy", 8'(busy_m), 8'd1);
        chk("t5 hold ready", 8'(s_ready_m), 8'd0);
        step();
        chk("t5 bit2", 8'(ser_bit_m), 8'd1);
        step();
        chk("t5 bit3", 8'(ser_bit_m), 8'd0);
        chk("t5 valid3", 8'(ser_valid_m), 8'd1);
        flush_m = 1'b1;
        #1;
        chk("t5 ready in flush", 8'(s_ready_m), 8'd0);
        step();
        flush_m = 1'b0;
        #1;
        chk("t5 valid post", 8'(ser_valid_m), 8'd0);
        chk("t5 bit post", 8'(ser_bit_m), 8'd0);
        chk("t5 last post", 8'(ser_last_m), 8'd0);
        chk("t5 busy post", 8'(busy_m), 8'd0);
        chk("t5 ready post", 8'(s_ready_m), 8'd1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("t5 quiet%0d", i), 8'(ser_valid_m), 8'd0);
        end
        // flush while idle blocks a waiting word
        s_data_m = 8'hFF; s_valid_m = 1'b1; flush_m = 1'b1;
        #1;
        chk("t5 idle flush ready", 8'(s_ready_m), 8'd0);
        step();
        flush_m = 1'b0; s_valid_m = 1'b0;
        chk("t5 idle flush valid", 8'(ser_valid_m), 8'd0);
        chk("t5 idle flush busy", 8'(busy_m), 8'd0);
        $display("txn flush a5: done");

        // 6. asynchronous reset during bit 5, then a fresh word
        s_data_m = 8'hFF; s_valid_m = 1'b1;
        step();
        s_valid_m = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("t6 valid5", 8'(ser_valid_m), 8'd1);
        chk("t6 bit5", 8'(ser_bit_m), 8'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6 async valid", 8'(ser_valid_m), 8'd0);
        chk("t6 async bit", 8'(ser_bit_m), 8'd0);
        chk("t6 async busy", 8'(busy_m), 8'd0);
        chk("t6 async ready", 8'(s_ready_m), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("t6 rel ready", 8'(s_ready_m), 8'd1);
        chk("t6 rel valid", 8'(ser_valid_m), 8'd0);
        s_data_m = 8'h80; s_valid_m = 1'b1;
        step();
        s_valid_m = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t6 bit%0d", i), 8'(ser_bit_m), 8'(i == 0));
            chk($sformatf("t6 last%0d", i), 8'(ser_last_m), 8'(i == 7));
            step();
        end
        chk("t6 valid after", 8'(ser_valid_m), 8'd0);
        $display("txn async reset: done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_bit_serializer.md
Name: seq_bit_serializer

Overview:
- Upstream feeder for the 110 Mealy sequence detector.
- Accepts parallel words over a valid/ready handshake and emits them as a serial bitstream, one bit per clock, with a bit-valid qualifier.
- A one-word hold buffer lets back-to-back words stream without gaps, so the detector sees a continuous bitstream that can overlap across word boundaries.

Parameters:
- DATA_W, 8, word width in bits (≥2).
- MSB_FIRST, 1, 1 = bit DATA_W-1 is sent first; 0 = bit 0 is sent first.
- IDLE_BIT, 0, value driven on ser_bit while ser_valid=0.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- s_data  in  DATA_W  parallel word to serialize.
- s_valid  in  1  s_data is valid.
- s_ready  out  1  block can accept a word this cycle.
- flush  in  1  synchronous abort: drops the held and in-flight word.
- ser_bit  out  1  serial data bit; connects to the detector's in.
- ser_valid  out  1  ser_bit is a real data bit this cycle.
- ser_last  out  1  ser_bit is the final bit of its word.
- busy  out  1  shifter or hold buffer is occupied.

Behaviour:
- **Reset (asynchronous, rst_n=0):**
  - Shifter, bit counter and hold buffer cleared; state=SER_IDLE.
  - Outputs: ser_valid=0, ser_last=0, ser_bit=IDLE_BIT, busy=0, s_ready=0 while rst_n=0.
  - s_ready rises on the first edge after rst_n deasserts.
- **Handshake:**
  - s_ready = !hold_full && !flush; combinational from registered state plus flush.
  - A transfer occurs at an edge where s_valid && s_ready.
  - s_data is sampled only on a transfer.
- **State machine (shared enum):**
  - SER_IDLE: nothing shifting. A transfer loads the word straight into the shifter, count=0, go to SER_SHIFT. The hold buffer is bypassed.
  - SER_SHIFT: each edge advances one bit.
  - On the edge that retires the last bit (count=DATA_W-1):
    - hold full → hold word moves to the shifter, count=0, stay in SER_SHIFT, hold cleared;
    - else if a transfer occurs on the same edge → incoming word goes directly to the shifter, stay in SER_SHIFT;
    - else → SER_IDLE.
  - A transfer on any other SER_SHIFT edge writes the hold buffer.
- **Outputs (all registered):**
  - Latency: word accepted at edge k → its first bit is on ser_bit/ser_valid in the cycle after edge k.
  - Remaining bits follow on consecutive cycles.
  - Throughput: 1 bit/clk sustained. No idle cycle between words if the next word is accepted at or before the edge retiring the last bit.
  - ser_last=1 exactly in the cycle carrying bit index DATA_W-1 of a word.
  - Whenever ser_valid=0: ser_bit=IDLE_BIT and ser_last=0.
- **Bit order:** MSB_FIRST=1 sends s_data[DATA_W-1] down to s_data[0]; MSB_FIRST=0 is the reverse.
- **Counter:** $clog2(DATA_W) bits. Wraps only by reload to 0; never exceeds DATA_W-1.
- **flush:**
  - At the edge: hold cleared, shifter cleared, state=SER_IDLE.
  - From the next cycle: ser_valid=0.
  - flush has priority over any transfer; s_ready is forced low during flush, so no word is lost silently.
- **busy** = (state==SER_SHIFT) || hold_full.
- **Reset mid-word:** output goes idle immediately (asynchronous); the partial word is discarded and nothing resumes.
- **s_valid without s_ready:** the word is not sampled. The upstream source must hold s_data stable until the transfer.

Decomposition:
- Package seq_pkg holds:
  - enum ser_state_t {SER_IDLE, SER_SHIFT};
  - the detector state enum (S0, S1, S2);
  - localparam DEFAULT_DATA_W=8.
- One natural sub-module: seq_hold_buf, the single-entry register with full flag, write, and pop-on-reload.
- Everything else lives in seq_bit_serializer.

Test Plan:
1. **Reset/idle:** rst_n low for 3 cycles, then high → ser_valid=0, ser_bit=0, busy=0; s_ready=1 from the first cycle after release.
2. **Single word, MSB_FIRST=1:** send 8'b0110_1100 → ser_bit 0,1,1,0,1,1,0,0 on 8 consecutive cycles starting 1 cycle after the transfer; ser_last only on the 8th. When chained to the detector, the detector output pulses during bit indices 3 and 6.
3. **Back-to-back, zero gap:** send 8'hFF then 8'h00 with s_valid held high → 16 contiguous ser_valid cycles, bits 1×8 then 0×8. s_ready drops after the second word enters hold and returns on the edge the first word's last bit retires.
4. **LSB_FIRST (MSB_FIRST=0):** send 8'b0000_0011 → bits 1,1,0,0,0,0,0,0 (detector pulses once, at bit index 2).
5. **Flush mid-word:** assert flush on the edge retiring bit index 3 of 8'hA5 while a second word sits in hold → ser_valid=0 from the next cycle, busy=0, hold word never emitted, s_ready=1 one cycle after flush drops.
6. **Async reset mid-word:** drop rst_n between edges during bit index 5 → ser_valid falls without waiting for a clock edge; the next word after release starts from bit 0.
